instr_sequencer: RTL and testbench

Parametrised successor to the board-level instruction FSM. It buffers up to DEPTH switch-entered instructions (queued in save order, last-entry delete) and plays them back as timed command steps, with an optional inter-step gap. It adds loop replay, pause/resume, abort and auto-start-on-full. It sits between the debounced KEY pulses / SW inputs and the torque/direction display blocks, which consume cmd_out/cmd_valid.

---
 rtl/seq_pkg.sv | 13 +
 rtl/step_timer.sv | 23 ++
 rtl/instr_sequencer.sv | 162 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and sizing helpers for the instruction sequencer.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, GAP, PAUSE} seq_state_e;

  // Width able to hold max(step, gap) - 1; never narrower than one bit.
  function automatic int timer_w(input int step, input int gap);
    int m;
    m = (step > gap) ? step : gap;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module step_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         enable_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt_q <= '0;
    else if (load_i)                   cnt_q <= load_val_i;
    else if (enable_i && cnt_q != '0)  cnt_q <= cnt_q - W'(1);
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Buffers switch-entered instructions and plays them back as timed steps
// with optional gaps, loop replay, pause/resume, abort and auto-run.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W           = 4,
  parameter int DEPTH            = 8,
  parameter int STEP_CYCLES      = 50_000_000,
  parameter int GAP_CYCLES       = 0,
  parameter int AUTO_RUN_ON_FULL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       save,
  input  logic                       delete,
  input  logic                       execute,
  input  logic                       pause,
  input  logic                       clear,
  input  logic                       loop_mode,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          cmd_out,
  output logic                       cmd_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = timer_w(STEP_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] STEP_LD = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  seq_state_e state_q, state_d, origin_q, origin_d, play_s;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] rd_q, rd_d;
  logic          done_q, done_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic          mem_we, tmr_load, tmr_en, tmr_zero, last_s;
  logic [TW-1:0] tmr_val;

  step_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .enable_i   (tmr_en),
    .zero_o     (tmr_zero)
  );

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign last_s    = (CW'(rd_q) + CW'(1) == count_q);
  assign cmd_valid = (state_q == RUN);
  assign cmd_out   = cmd_valid ? mem_q[rd_q] : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign count     = count_q;
  assign step_idx  = busy ? rd_q : '0;

  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    count_d  = count_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = STEP_LD;
    tmr_en   = 1'b0;
    play_s   = state_q;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (execute) begin
            if (!empty) begin
              state_d  = RUN;
              rd_d     = '0;
              tmr_load = 1'b1;
            end
          end else if (save) begin
            if (!full) begin
              mem_we  = 1'b1;
              count_d = count_q + CW'(1);
              if (AUTO_RUN_ON_FULL != 0 && count_q == CW'(DEPTH - 1)) begin
                state_d  = RUN;
                rd_d     = '0;
                tmr_load = 1'b1;
              end
            end
          end else if (delete && !empty) begin
            count_d = count_q - CW'(1);
          end
        end
        RUN, GAP: begin
          if (execute) begin
            state_d = IDLE;
          end else begin
            if (!tmr_zero) begin
              tmr_en = 1'b1;
            end else if (state_q == RUN && GAP_CYCLES > 0) begin
              play_s   = GAP;
              tmr_load = 1'b1;
              tmr_val  = GAP_LD;
            end else if (!last_s) begin
              rd_d     = rd_q + IW'(1);
              play_s   = RUN;
              tmr_load = 1'b1;
            end else if (loop_mode) begin
              rd_d     = '0;
              play_s   = RUN;
              tmr_load = 1'b1;
            end else begin
              play_s  = IDLE;
              count_d = '0;
              done_d  = 1'b1;
            end
            // A pause on a boundary parks on the step it would have entered.
            if (pause && play_s != IDLE) begin
              state_d  = PAUSE;
              origin_d = play_s;
            end else begin
              state_d = play_s;
            end
          end
        end
        PAUSE: begin
          if (execute)    state_d = IDLE;
          else if (pause) state_d = origin_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      origin_q <= RUN;
      count_q  <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      origin_q <= origin_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[IW-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: expected step values queued at execute, popped per valid cycle.
module tb_instr_sequencer;

  localparam int DW  = 4;
  localparam int DEP = 4;
  localparam int ST  = 5;
  localparam int GP  = 2;
  localparam int CW  = $clog2(DEP+1);
  localparam int IW  = $clog2(DEP);

  logic clk, rst_n, save, delete, execute, pause, clear, loop_mode;
  logic [DW-1:0] data_in;
  logic [DW-1:0] cmd_out, a_cmd_out;
  logic cmd_valid, busy, done, full, empty;
  logic a_cmd_valid, a_busy, a_done, a_full, a_empty;
  logic [CW-1:0] count, a_count;
  logic [IW-1:0] step_idx, a_step_idx;

  instr_sequencer #(.DATA_W(DW), .DEPTH(DEP), .STEP_CYCLES(ST), .GAP_CYCLES(GP),
                    .AUTO_RUN_ON_FULL(0)) dut (
    .clk(clk), .rst_n(rst_n), .save(save), .delete(delete), .execute(execute),
    .pause(pause), .clear(clear), .loop_mode(loop_mode), .data_in(data_in),
    .cmd_out(cmd_out), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .count(count), .step_idx(step_idx), .full(full), .empty(empty));

  instr_sequencer #(.DATA_W(DW), .DEPTH(DEP), .STEP_CYCLES(ST), .GAP_CYCLES(GP),
                    .AUTO_RUN_ON_FULL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .save(save), .delete(delete), .execute(execute),
    .pause(pause), .clear(clear), .loop_mode(loop_mode), .data_in(data_in),
    .cmd_out(a_cmd_out), .cmd_valid(a_cmd_valid), .busy(a_busy), .done(a_done),
    .count(a_count), .step_idx(a_step_idx), .full(a_full), .empty(a_empty));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] sb[$];
  int n_chk = 0, n_fail = 0, n_done = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Every presented step must match the next queued expectation.
  always @(negedge clk) begin
    if (cmd_valid) begin
      if (sb.size() == 0) chk("sb_empty", sb.size(), 1);
      else                chk("cmd", cmd_out, sb.pop_front());
    end else begin
      chk("cmd_zero", cmd_out, 0);
    end
    if (done) n_done++;
  end

  task automatic push_step(input logic [DW-1:0] v);
    repeat (ST) sb.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic nedge();
    @(negedge clk); #1;
  endtask

  task automatic do_save(input logic [DW-1:0] d);
    data_in = d; save = 1'b1; tick(); save = 1'b0;
  endtask
  task automatic do_del();   delete  = 1'b1; tick(); delete  = 1'b0; endtask
  task automatic do_exec();  execute = 1'b1; tick(); execute = 1'b0; endtask
  task automatic do_pause(); pause   = 1'b1; tick(); pause   = 1'b0; endtask
  task automatic do_clear(); clear   = 1'b1; tick(); clear   = 1'b0; endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin nedge(); n++; end
    chk(tag, busy, 0);
  endtask

  initial begin
    int d0, n;
    rst_n = 1'b0; save = 0; delete = 0; execute = 0; pause = 0; clear = 0;
    loop_mode = 0; data_in = '0;
    repeat (2) nedge();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_done",  done, 0);
    chk("rst_idx",   step_idx, 0);
    rst_n = 1'b1;
    tick();

    // 1: three entries, single shot with gaps
    do_save(4'h1); do_save(4'h6); do_save(4'hA);
    chk("t1_count", count, 3);
    push_step(4'h1); push_step(4'h6); push_step(4'hA);
    d0 = n_done;
    do_exec();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk); #1;
      chk($sformatf("t1_valid%0d", i), cmd_valid, (i < 21 && (i % 7) < 5) ? 1 : 0);
      if (i == 8) chk("t1_idx", step_idx, 1);
    end
    chk("t1_done",  done, 1);
    chk("t1_count0", count, 0);
    chk("t1_empty", empty, 1);
    nedge();
    chk("t1_done1", n_done, d0 + 1);
    chk("t1_sb", sb.size(), 0);

    // 2: overflow ignored, delete twice, play first two
    do_clear();
    do_save(4'h2); do_save(4'h3); do_save(4'h4); do_save(4'h5); do_save(4'h7);
    chk("t2_count4", count, 4);
    chk("t2_full", full, 1);
    do_del(); do_del();
    chk("t2_count2", count, 2);
    push_step(4'h2); push_step(4'h3);
    do_exec();
    wait_idle("t2_idle");
    chk("t2_sb", sb.size(), 0);

    // 3: loop replay then clear mid-step
    do_clear();
    loop_mode = 1'b1;
    do_save(4'h8); do_save(4'h9);
    repeat (4) begin push_step(4'h8); push_step(4'h9); end
    d0 = n_done;
    do_exec();
    n = 0;
    while (sb.size() > 8 && n < 200) begin nedge(); n++; end
    chk("t3_progress", sb.size(), 8);
    do_clear();
    nedge();
    chk("t3_valid", cmd_valid, 0);
    chk("t3_count", count, 0);
    chk("t3_busy",  busy, 0);
    chk("t3_nodone", n_done, d0);
    sb.delete();
    loop_mode = 1'b0;

    // 4: pause at cycle 2 of a step, resume, then abort from PAUSE
    do_save(4'hC); do_save(4'hD);
    push_step(4'hC); push_step(4'hD);
    d0 = n_done;
    do_exec();
    tick();
    do_pause();
    for (int i = 0; i < 10; i++) begin
      nedge();
      chk("t4_held", {busy, cmd_valid}, 2'b10);
    end
    chk("t4_sb_frozen", sb.size(), 8);
    do_pause();
    n = 0;
    nedge();
    while (cmd_valid && n < 10) begin n++; nedge(); end
    chk("t4_resume", n, 3);
    do_pause();
    chk("t4_paused", {busy, cmd_valid}, 2'b10);
    do_exec();
    nedge();
    chk("t4_abort", busy, 0);
    chk("t4_count", count, 2);
    chk("t4_nodone", n_done, d0);
    chk("t4_sb", sb.size(), 5);
    sb.delete();

    // 5: auto-run on full; edits ignored during playback
    do_clear();
    do_save(4'h1); do_save(4'h2); do_save(4'h3);
    chk("t5_pre", a_busy, 0);
    do_save(4'h4);
    nedge();
    chk("t5_auto", a_busy, 1);
    chk("t5_avalid", a_cmd_valid, 1);
    chk("t5_acmd", a_cmd_out, 1);
    chk("t5_noauto", busy, 0);
    do_save(4'hF); do_del();
    chk("t5_acount", a_count, 4);
    n = 0;
    while (a_step_idx != 1 && n < 40) begin nedge(); n++; end
    chk("t5_acmd2", a_cmd_out, 2);
    n = 0;
    while (a_busy && n < 200) begin nedge(); n++; end
    chk("t5_aidle", a_count, 0);

    // 6: asynchronous reset mid-RUN
    do_clear();
    do_save(4'h1); do_save(4'h2);
    push_step(4'h1); push_step(4'h2);
    do_exec();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", cmd_valid, 0);
    chk("t6_cmd",   cmd_out, 0);
    chk("t6_busy",  busy, 0);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_idx",   step_idx, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_exec();
    chk("t6_stayidle", busy, 0);
    chk("t6_empty2", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
